// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the x1 fetch stage: instruction field slices,
// the NOP word and the fetch FSM state encoding.
package inst_fetch_pkg;

    localparam int X1_INSTR_W = 35;

    // Instruction field slices, used by decode; fetch treats the word as opaque.
    localparam int OP_MSB   = 34;
    localparam int OP_LSB   = 31;
    localparam int FUNC_MSB = 30;
    localparam int FUNC_LSB = 28;
    localparam int SRC1_MSB = 27;
    localparam int SRC1_LSB = 18;
    localparam int SRC2_MSB = 17;
    localparam int SRC2_LSB = 8;
    localparam int ADDR_MSB = 7;
    localparam int ADDR_LSB = 0;

    localparam logic [X1_INSTR_W-1:0] NOP_WORD = '0;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM address/data, execute-side control and the IR outputs.
interface inst_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 35,
    parameter int CNT_W   = 8
);
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               stall;
    logic               br_taken;
    logic [ADDR_W-1:0]  br_target;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_valid;
    logic [CNT_W-1:0]   br_count;

    modport master (
        output rom_addr, pc, ir, ir_pc, ir_valid, br_count,
        input  rom_data, stall, br_taken, br_target
    );

    modport slave (
        input  rom_addr, pc, ir, ir_pc, ir_valid, br_count,
        output rom_data, stall, br_taken, br_target
    );
endinterface

// File: rtl/inst_fetch_sat_counter.sv
// Saturating up-counter for debug statistics; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;

    // NOTE: combinational blocks give every output a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/inst_fetch.sv
// x1 fetch stage: drives the ROM address from pc, registers the word into IR,
// and handles stalls and branch redirects with a single NOP bubble.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 35,
    parameter int RST_PC  = 0,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    inst_fetch_if.master  bus
);
    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic               ir_valid_q, ir_valid_d;
    logic               redirect;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        redirect   = 1'b0;

        case (state_q)
            S_RUN: begin
                if (bus.br_taken) begin
                    pc_d       = bus.br_target;
                    ir_d       = INSTR_W'(NOP_WORD);
                    ir_valid_d = 1'b0;
                    redirect   = 1'b1;
                    state_d    = S_FLUSH;
                end else if (!bus.stall) begin
                    ir_d       = bus.rom_data;
                    ir_pc_d    = pc_q;
                    ir_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_W'(1);
                end
            end
            // FILL and FLUSH hold an empty IR, so stall/branch cannot apply.
            default: begin
                ir_d       = bus.rom_data;
                ir_pc_d    = pc_q;
                ir_valid_d = 1'b1;
                pc_d       = pc_q + ADDR_W'(1);
                state_d    = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            pc_q       <= ADDR_W'(RST_PC);
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect),
        .count (bus.br_count)
    );

    assign bus.rom_addr = pc_q;
    assign bus.pc       = pc_q;
    assign bus.ir       = ir_q;
    assign bus.ir_pc    = ir_pc_q;
    assign bus.ir_valid = ir_valid_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: two instances (RST_PC=0/CNT_W=8 and
// RST_PC=254/CNT_W=2) share stimulus and are checked against a pipeline model.
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int AW = 8;
    localparam int IW = 35;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] ir;
        logic [AW-1:0] ir_pc;
        logic          v;
        int            cnt;
    } model_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          br_taken = 1'b0;
    logic [AW-1:0] br_target = '0;
    logic [IW-1:0] rom [256];

    int n_tests = 0;
    int n_fail  = 0;

    model_t ma, mb, ea, eb;
    model_t q_a[$];
    model_t q_b[$];

    always #5 clk = ~clk;

    inst_fetch_if #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(8)) bus_a ();
    inst_fetch_if #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(2)) bus_b ();

    assign bus_a.rom_data  = rom[bus_a.rom_addr];
    assign bus_a.stall     = stall;
    assign bus_a.br_taken  = br_taken;
    assign bus_a.br_target = br_target;
    assign bus_b.rom_data  = rom[bus_b.rom_addr];
    assign bus_b.stall     = stall;
    assign bus_b.br_taken  = br_taken;
    assign bus_b.br_target = br_target;

    inst_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RST_PC(0), .CNT_W(8)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
    );
    inst_fetch #(.ADDR_W(AW), .INSTR_W(IW), .RST_PC(254), .CNT_W(2)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
    );

    // Pipeline model: an empty IR (after reset or a redirect) always refills;
    // a full IR redirects on br_taken, holds on stall, otherwise advances.
    function automatic model_t model_next(model_t m, bit r, bit s, bit b,
                                          logic [AW-1:0] t, int rst_pc, int cnt_max);
        model_t n = m;
        if (r) begin
            n.pc = AW'(rst_pc); n.ir = '0; n.ir_pc = '0; n.v = 1'b0; n.cnt = 0;
        end else if (m.v && b) begin
            n.pc = t; n.ir = '0; n.v = 1'b0;
            n.cnt = (m.cnt < cnt_max) ? m.cnt + 1 : cnt_max;
        end else if (m.v && s) begin
            n = m;
        end else begin
            n.ir = rom[m.pc]; n.ir_pc = m.pc; n.v = 1'b1;
            n.pc = AW'((int'(m.pc) + 1) % 256);
        end
        return n;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(string tag, model_t e, logic [AW-1:0] pc, logic [AW-1:0] ra,
                           logic [IW-1:0] ir, logic [AW-1:0] ir_pc, logic v, logic [7:0] cnt);
        check({tag, ".pc"},       64'(pc),    64'(e.pc));
        check({tag, ".rom_addr"}, 64'(ra),    64'(e.pc));
        check({tag, ".ir"},       64'(ir),    64'(e.ir));
        check({tag, ".ir_pc"},    64'(ir_pc), 64'(e.ir_pc));
        check({tag, ".ir_valid"}, 64'(v),     64'(e.v));
        check({tag, ".br_count"}, 64'(cnt),   64'(e.cnt));
    endtask

    // Monitor: pops one expected snapshot per DUT after every edge.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            cmp_dut("a", ea, bus_a.pc, bus_a.rom_addr, bus_a.ir, bus_a.ir_pc,
                    bus_a.ir_valid, 8'(bus_a.br_count));
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            cmp_dut("b", eb, bus_b.pc, bus_b.rom_addr, bus_b.ir, bus_b.ir_pc,
                    bus_b.ir_valid, 8'(bus_b.br_count));
        end
    end

    task automatic step(bit r, bit s, bit b, logic [AW-1:0] t);
        @(negedge clk);
        rst = r; stall = s; br_taken = b; br_target = t;
        ma = model_next(ma, r, s, b, t, 0, 255);
        mb = model_next(mb, r, s, b, t, 254, 3);
        q_a.push_back(ma);
        q_b.push_back(mb);
    endtask

    task automatic run_to(logic [AW-1:0] target);
        int k = 0;
        while (!(ma.v && ma.ir_pc == target) && k < 600) begin
            step(0, 0, 0, '0);
            k++;
        end
        if (k >= 600) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_to: ir_pc %0d not reached, at %0h", target, ma.ir_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {27'($urandom), 8'(i)};
        rom[3] = '0;
        ma = '{pc: '0, ir: '0, ir_pc: '0, v: 1'b0, cnt: 0};
        mb = ma;

        step(1, 0, 0, '0);
        step(1, 1, 1, 8'd77);          // reset beats stall and br_taken
        step(0, 1, 0, '0);             // fill ignores stall
        run_to(8'd5);
        repeat (3) step(0, 1, 0, '0);
        step(0, 0, 0, '0);
        run_to(8'd8);
        step(0, 0, 1, 8'd4);
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        run_to(8'd7);
        step(0, 1, 1, 8'd20);          // branch overrides stall
        step(0, 1, 1, 8'd99);          // flush ignores both
        step(0, 0, 0, '0);
        step(0, 0, 1, ma.pc - 8'd1);   // target equal to the IR address
        step(0, 0, 0, '0);
        step(0, 1, 1, 8'd30);
        step(1, 0, 0, '0);             // reset during flush
        step(0, 0, 0, '0);

        // Five redirects back-to-back: CNT_W=2 instance saturates at 3.
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 8'($urandom));
            step(0, 0, 0, '0);
        end

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 15, 8'($urandom));
        end

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(q_a.size() + q_b.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
